masked_adder_scheduler: RTL and testbench

- Shares one pipelined masked 2+3-bit adder (3-share-bit a, 2-bit b, 3-bit c, d shares per bit) between two requesters using round-robin arbitration.
- Feeds fresh randomness to the adder's HPC2 gadgets and tracks in-flight operations with a tag pipeline.
- Returns each result tagged with its requester ID.
- Sits between the polynomial/rounding datapath clients and the adder gadget. The adder itself is instantiated outside this block.

---
 rtl/masked_adder_scheduler.sv | 79 +++++++
 tb/tb_masked_adder_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/masked_adder_scheduler.sv
// masked_adder_scheduler: round-robin sharing of one pipelined masked adder between two requesters
module masked_adder_scheduler #(
    parameter int D    = 2,
    parameter int LAT  = 4,
    parameter int NRND = 4*D*(D-1)/2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3*D-1:0]  req0_a,
    input  logic [2*D-1:0]  req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3*D-1:0]  req1_a,
    input  logic [2*D-1:0]  req1_b,
    input  logic [NRND-1:0] rnd_in,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic [3*D-1:0]  add_a,
    output logic [2*D-1:0]  add_b,
    output logic [NRND-1:0] add_rnd,
    input  logic [3*D-1:0]  add_c,
    output logic            res_valid,
    output logic            res_id,
    output logic [3*D-1:0]  res_c,
    output logic            busy,
    output logic            rnd_err
);
    localparam int CW = $clog2(LAT+1);

    logic            w_issue;
    logic            w_gnt_id;
    logic            w_inflight;
    logic            r_rr_ptr;
    logic [LAT-1:0]  r_tag_v;
    logic [LAT-1:0]  r_tag_id;
    logic [CW-1:0]   r_cnt;
    logic [NRND-1:0] r_add_rnd;
    logic            r_rnd_err;

    assign w_issue    = rnd_valid & (req0_valid | req1_valid);
    assign w_gnt_id   = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;
    assign w_inflight = r_cnt != '0;

    // Grant decode and operand mux; an idle adder sees an all-zero sharing so unselected shares never leak in
    always_comb begin
        req0_ready = w_issue & !w_gnt_id;
        req1_ready = w_issue & w_gnt_id;
        add_a      = !w_issue ? '0 : (w_gnt_id ? req1_a : req0_a);
        add_b      = !w_issue ? '0 : (w_gnt_id ? req1_b : req0_b);
        rnd_ready  = rnd_valid & (w_issue | w_inflight);
        busy       = w_issue | w_inflight;
        res_valid  = r_tag_v[LAT-1];
        res_id     = r_tag_id[LAT-1];
        res_c      = add_c;
        add_rnd    = r_add_rnd;
        rnd_err    = r_rnd_err;
    end

    // Arbitration pointer, tag pipeline, occupancy count and per-cycle randomness refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= 1'b0;
            r_tag_v   <= '0;
            r_tag_id  <= '0;
            r_cnt     <= '0;
            r_add_rnd <= '0;
            r_rnd_err <= 1'b0;
        end else begin
            if (w_issue) r_rr_ptr <= !w_gnt_id;
            r_tag_v  <= {r_tag_v[LAT-2:0], w_issue};
            r_tag_id <= {r_tag_id[LAT-2:0], w_issue & w_gnt_id};
            r_cnt    <= r_cnt + CW'(w_issue) - CW'(r_tag_v[LAT-1]);
            if (rnd_ready) r_add_rnd <= rnd_in;
            if (w_inflight & !rnd_valid) r_rnd_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_masked_adder_scheduler.sv
// tb_masked_adder_scheduler: directed checks of arbitration, tagging, randomness gating and reset
module tb_masked_adder_scheduler;
    localparam int D    = 2;
    localparam int LAT  = 4;
    localparam int NRND = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3*D-1:0]  req0_a, req1_a, add_a, add_c, res_c;
    logic [2*D-1:0]  req0_b, req1_b, add_b;
    logic [NRND-1:0] rnd_in, add_rnd;
    logic            rnd_valid, rnd_ready, res_valid, res_id, busy, rnd_err;
    logic [3*D-1:0]  p [LAT];
    int              n_cmp = 0;
    int              n_fail = 0;

    masked_adder_scheduler #(.D(D), .LAT(LAT), .NRND(NRND)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .add_a(add_a), .add_b(add_b), .add_rnd(add_rnd), .add_c(add_c),
        .res_valid(res_valid), .res_id(res_id), .res_c(res_c),
        .busy(busy), .rnd_err(rnd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] um3(input logic [3*D-1:0] x);
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = ^x[D*i +: D];
        return v;
    endfunction

    function automatic logic [1:0] um2(input logic [2*D-1:0] x);
        logic [1:0] v;
        for (int i = 0; i < 2; i++) v[i] = ^x[D*i +: D];
        return v;
    endfunction

    function automatic logic [3*D-1:0] mask3(input logic [2:0] v);
        logic [3*D-1:0] x;
        logic [D-1:0]   s;
        for (int i = 0; i < 3; i++) begin
            s = D'($urandom);
            s[D-1] = ^s[D-2:0] ^ v[i];
            x[D*i +: D] = s;
        end
        return x;
    endfunction

    function automatic logic [2*D-1:0] mask2(input logic [1:0] v);
        logic [2*D-1:0] x;
        logic [D-1:0]   s;
        for (int i = 0; i < 2; i++) begin
            s = D'($urandom);
            s[D-1] = ^s[D-2:0] ^ v[i];
            x[D*i +: D] = s;
        end
        return x;
    endfunction

    // Stand-in for the external masked adder: LAT-cycle pipeline that re-masks the true sum
    always @(posedge clk) begin
        p[0] <= mask3(um3(add_a) + {1'b0, um2(add_b)});
        for (int k = 1; k < LAT; k++) p[k] <= p[k-1];
    end
    assign add_c = p[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rnd_in = '0; rnd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_rnd_ready", rnd_ready, 0);
        chk("rst_add_rnd", add_rnd, 0);
        chk("rst_rnd_err", rnd_err, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        @(negedge clk); rst = 1'b0;

        // single op: 3 + 2 = 5 from requester 0
        @(negedge clk);
        req0_valid = 1'b1; req0_a = mask3(3); req0_b = mask2(2); rnd_valid = 1'b1; rnd_in = 4'hA;
        #1;
        chk("s_req0_ready", req0_ready, 1);
        chk("s_req1_ready", req1_ready, 0);
        chk("s_rnd_ready", rnd_ready, 1);
        chk("s_busy", busy, 1);
        chk("s_add_a", um3(add_a), 3);
        chk("s_add_b", um2(add_b), 2);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            req0_valid = 1'b0; rnd_in = NRND'(i);
            #1;
            if (i == 1) chk("s_add_rnd", add_rnd, 4'hA);
            chk("s_res_valid", res_valid, (i == LAT));
            if (i == LAT) begin
                chk("s_res_id", res_id, 0);
                chk("s_res_c", um3(res_c), 5);
            end
        end
        @(negedge clk); #1;
        chk("s_busy_after", busy, 0);
        chk("s_res_valid_after", res_valid, 0);
        chk("s_rnd_ready_idle", rnd_ready, 0);

        // contention: alternating grants starting with requester 0
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req0_valid = (i < 6); req1_valid = (i < 6);
            req0_a = mask3(7); req0_b = mask2(3); req1_a = mask3(0); req1_b = mask2(0);
            rnd_valid = 1'b1;
            #1;
            if (i < 6) begin
                chk("c_req0_ready", req0_ready, (i % 2 == 0));
                chk("c_req1_ready", req1_ready, (i % 2 == 1));
                chk("c_add_a", um3(add_a), (i % 2 == 1) ? 0 : 7);
            end
            chk("c_res_valid", res_valid, (i >= LAT));
            if (i >= LAT) begin
                chk("c_res_id", res_id, i % 2);
                chk("c_res_c", um3(res_c), (i % 2 == 1) ? 0 : 2);
            end
        end
        @(negedge clk); #1;
        chk("c_res_valid_after", res_valid, 0);
        chk("c_busy_after", busy, 0);

        // randomness gating: requester 1 waits for rnd_valid
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1_valid = 1'b1; req1_a = mask3(5); req1_b = mask2(1); rnd_valid = 1'b0;
            #1;
            chk("g_req1_ready", req1_ready, 0);
            chk("g_rnd_ready", rnd_ready, 0);
            chk("g_busy", busy, 0);
        end
        @(negedge clk); rnd_valid = 1'b1; rnd_in = 4'h3; #1;
        chk("g_req1_ready_go", req1_ready, 1);
        chk("g_req0_ready_go", req0_ready, 0);
        chk("g_rnd_ready_go", rnd_ready, 1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); req1_valid = 1'b0; #1;
            chk("g_res_valid", res_valid, (i == LAT));
            if (i == LAT) begin
                chk("g_res_id", res_id, 1);
                chk("g_res_c", um3(res_c), 6);
            end
            chk("g_rnd_err", rnd_err, 0);
        end

        // starvation: randomness drops while an op is in flight
        @(negedge clk);
        req0_valid = 1'b1; req0_a = mask3(2); req0_b = mask2(1); rnd_valid = 1'b1; rnd_in = 4'h5;
        #1;
        chk("v_req0_ready", req0_ready, 1);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk); req0_valid = 1'b0; rnd_valid = 1'b0; rnd_in = 4'hF; #1;
            chk("v_rnd_ready", rnd_ready, 0);
            if (i >= 2) begin
                chk("v_rnd_err", rnd_err, 1);
                chk("v_add_rnd", add_rnd, 4'h5);
            end
            chk("v_res_valid", res_valid, (i == LAT));
            if (i == LAT) begin
                chk("v_res_id", res_id, 0);
                chk("v_res_c", um3(res_c), 3);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rnd_valid = 1'b1; #1;
            chk("v_rnd_err_sticky", rnd_err, 1);
        end

        // reset mid-flight: three issues, then rst; nothing returns and the pointer restarts at 0
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_a = mask3(3'(i)); req0_b = mask2(0); rnd_valid = 1'b1;
            #1;
            chk("r_req0_ready", req0_ready, 1);
        end
        @(negedge clk); req0_valid = 1'b0; rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rst = 1'b0; #1;
            chk("r_res_valid", res_valid, 0);
            chk("r_busy", busy, 0);
            chk("r_rnd_err", rnd_err, 0);
        end
        @(negedge clk); req0_valid = 1'b1; req1_valid = 1'b1; rnd_valid = 1'b1; #1;
        chk("r_req0_ready_ptr", req0_ready, 1);
        chk("r_req1_ready_ptr", req1_ready, 0);
        @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (5) @(negedge clk);

        // idle hygiene
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); rnd_valid = 1'b1; rnd_in = NRND'($urandom); #1;
            chk("i_add_a", add_a, 0);
            chk("i_add_b", add_b, 0);
            chk("i_rnd_ready", rnd_ready, 0);
            chk("i_res_valid", res_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
